hazard_stall_ctrl: RTL and testbench

Pipeline control block that drives the enable and flush inputs of the PC, F/D, D/X, X/M and M/W pipeline latches, and the operand-bypass selects of the X stage. It decodes the instruction fields held in each latch. It detects load-use hazards and taken-branch flushes. It runs a multi-cycle mult/div handshake FSM that stalls the front of the pipe until the result is ready or a timeout expires.

---
 rtl/hazard_stall_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: operand bypass selects, load-use stall,
// taken-branch flush and a stalling handshake FSM for the mult/div unit.
module hazard_stall_ctrl #(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] insn_fd,
  input  logic [31:0] insn_dx,
  input  logic [31:0] insn_xm,
  input  logic [31:0] insn_mw,
  input  logic        branch_taken_x,
  input  logic        md_result_rdy,
  output logic        en_pc,
  output logic        en_fd,
  output logic        en_dx,
  output logic        en_xm,
  output logic        en_mw,
  output logic        flush_fd,
  output logic        flush_dx,
  output logic        bubble_xm,
  output logic        md_start,
  output logic        md_result_sel,
  output logic        md_busy,
  output logic        md_timeout,
  output logic [1:0]  byp_a_sel,
  output logic [1:0]  byp_b_sel
);

  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

  // Register references are {valid, regnum}; a destination of r0 is never valid.
  function automatic logic [5:0] dest_of(input logic [4:0] op, input logic [4:0] rd);
    logic [5:0] d;
    d = 6'd0;
    case (op)
      OP_RTYPE, OP_ADDI, OP_LW: d = {1'b1, rd};
      OP_JAL:                   d = {1'b1, 5'd31};
      OP_SETX:                  d = {1'b1, 5'd30};
      default:                  d = 6'd0;
    endcase
    if (d[4:0] == 5'd0) d = 6'd0;
    return d;
  endfunction

  function automatic logic [5:0] src_a_of(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs);
    case (op)
      OP_RTYPE, OP_ADDI, OP_LW, OP_SW: return {1'b1, rs};
      OP_BNE, OP_BLT, OP_JR:           return {1'b1, rd};
      OP_BEX:                          return {1'b1, 5'd30};
      default:                         return 6'd0;
    endcase
  endfunction

  function automatic logic [5:0] src_b_of(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [4:0] rt);
    case (op)
      OP_RTYPE:       return {1'b1, rt};
      OP_SW:          return {1'b1, rd};
      OP_BNE, OP_BLT: return {1'b1, rs};
      default:        return 6'd0;
    endcase
  endfunction

  function automatic logic [1:0] byp_of(input logic [5:0] src, input logic [5:0] xm_dest,
                                        input logic [5:0] mw_dest, input logic xm_is_lw);
    if (src[5] && xm_dest[5] && !xm_is_lw && src[4:0] == xm_dest[4:0]) return 2'b01;
    if (src[5] && mw_dest[5] && src[4:0] == mw_dest[4:0])               return 2'b10;
    return 2'b00;
  endfunction

  logic [4:0] op_fd, op_dx, op_xm, op_mw;
  logic [5:0] fd_src_a, fd_src_b, dx_src_a, dx_src_b, dx_dest, xm_dest, mw_dest;
  logic       dx_is_md, load_use;
  logic [1:0] byp_a, byp_b;
  logic       unused_bits;

  md_state_t        state, next_state;
  logic [CNT_W-1:0] md_cnt;

  assign op_fd = insn_fd[31:27];
  assign op_dx = insn_dx[31:27];
  assign op_xm = insn_xm[31:27];
  assign op_mw = insn_mw[31:27];

  assign fd_src_a = src_a_of(op_fd, insn_fd[26:22], insn_fd[21:17]);
  assign fd_src_b = src_b_of(op_fd, insn_fd[26:22], insn_fd[21:17], insn_fd[16:12]);
  assign dx_src_a = src_a_of(op_dx, insn_dx[26:22], insn_dx[21:17]);
  assign dx_src_b = src_b_of(op_dx, insn_dx[26:22], insn_dx[21:17], insn_dx[16:12]);
  assign dx_dest  = dest_of(op_dx, insn_dx[26:22]);
  assign xm_dest  = dest_of(op_xm, insn_xm[26:22]);
  assign mw_dest  = dest_of(op_mw, insn_mw[26:22]);

  assign dx_is_md = (op_dx == OP_RTYPE) && (insn_dx[6:2] == 5'b00110 || insn_dx[6:2] == 5'b00111);
  assign load_use = (op_dx == OP_LW) && dx_dest[5] &&
                    ((fd_src_a[5] && fd_src_a[4:0] == dx_dest[4:0]) ||
                     (fd_src_b[5] && fd_src_b[4:0] == dx_dest[4:0]));

  assign byp_a = byp_of(dx_src_a, xm_dest, mw_dest, op_xm == OP_LW);
  assign byp_b = byp_of(dx_src_b, xm_dest, mw_dest, op_xm == OP_LW);

  assign unused_bits = ^{insn_fd[11:0], insn_dx[11:7], insn_dx[1:0],
                         insn_xm[21:0], insn_mw[21:0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= MD_IDLE;
      md_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == MD_BUSY) md_cnt <= md_cnt + 1'b1;
      else                  md_cnt <= '0;
    end
  end

  // Branch and load-use handling only apply in MD_IDLE; reset forces the quiet pattern.
  always_comb begin
    next_state    = state;
    en_pc         = 1'b1;
    en_fd         = 1'b1;
    en_dx         = 1'b1;
    en_xm         = 1'b1;
    en_mw         = 1'b1;
    flush_fd      = 1'b0;
    flush_dx      = 1'b0;
    bubble_xm     = 1'b0;
    md_start      = 1'b0;
    md_result_sel = 1'b0;
    md_busy       = 1'b0;
    md_timeout    = 1'b0;
    byp_a_sel     = byp_a;
    byp_b_sel     = byp_b;
    case (state)
      MD_IDLE: begin
        if (dx_is_md) begin
          md_start   = 1'b1;
          en_pc      = 1'b0;
          en_fd      = 1'b0;
          en_dx      = 1'b0;
          bubble_xm  = 1'b1;
          next_state = MD_BUSY;
        end else if (branch_taken_x) begin
          flush_fd = 1'b1;
          flush_dx = 1'b1;
        end else if (load_use) begin
          en_pc    = 1'b0;
          en_fd    = 1'b0;
          flush_dx = 1'b1;
        end
      end
      MD_BUSY: begin
        md_busy   = 1'b1;
        en_pc     = 1'b0;
        en_fd     = 1'b0;
        en_dx     = 1'b0;
        bubble_xm = 1'b1;
        if (md_result_rdy) begin
          next_state = MD_DONE;
        end else if (md_cnt == CNT_LAST) begin
          md_timeout = 1'b1;
          next_state = MD_DONE;
        end
      end
      MD_DONE: begin
        md_result_sel = 1'b1;
        next_state    = MD_IDLE;
      end
      default: next_state = MD_IDLE;
    endcase
    if (reset) begin
      next_state    = MD_IDLE;
      en_pc         = 1'b1;
      en_fd         = 1'b1;
      en_dx         = 1'b1;
      en_xm         = 1'b1;
      en_mw         = 1'b1;
      flush_fd      = 1'b0;
      flush_dx      = 1'b0;
      bubble_xm     = 1'b0;
      md_start      = 1'b0;
      md_result_sel = 1'b0;
      md_busy       = 1'b0;
      md_timeout    = 1'b0;
      byp_a_sel     = 2'b00;
      byp_b_sel     = 2'b00;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed scoreboard bench for hazard_stall_ctrl: bypass, load-use, branch,
// mult/div handshake with rdy, timeout and reset-abort.
module tb_hazard_stall_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] insn_fd, insn_dx, insn_xm, insn_mw;
  logic        branch_taken_x, md_result_rdy;
  logic        en_pc, en_fd, en_dx, en_xm, en_mw;
  logic        flush_fd, flush_dx, bubble_xm;
  logic        md_start, md_result_sel, md_busy, md_timeout;
  logic [1:0]  byp_a_sel, byp_b_sel;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [15:0] exp_q[$];
  string       tag_q[$];

  hazard_stall_ctrl #(.MD_TIMEOUT(8), .CNT_W(4)) dut (
    .clock(clock), .reset(reset),
    .insn_fd(insn_fd), .insn_dx(insn_dx), .insn_xm(insn_xm), .insn_mw(insn_mw),
    .branch_taken_x(branch_taken_x), .md_result_rdy(md_result_rdy),
    .en_pc(en_pc), .en_fd(en_fd), .en_dx(en_dx), .en_xm(en_xm), .en_mw(en_mw),
    .flush_fd(flush_fd), .flush_dx(flush_dx), .bubble_xm(bubble_xm),
    .md_start(md_start), .md_result_sel(md_result_sel), .md_busy(md_busy),
    .md_timeout(md_timeout), .byp_a_sel(byp_a_sel), .byp_b_sel(byp_b_sel)
  );

  always #5 clock = ~clock;

  // Expected vector: {en pc,fd,dx,xm,mw | flush_fd,flush_dx,bubble_xm,start,sel,busy,timeout | byp_a | byp_b}
  localparam logic [4:0] EN_ALL  = 5'b11111;
  localparam logic [4:0] EN_LU   = 5'b00111;
  localparam logic [4:0] EN_MD   = 5'b00011;
  localparam logic [6:0] C_NONE  = 7'b0000000;
  localparam logic [6:0] C_LU    = 7'b0100000;
  localparam logic [6:0] C_BR    = 7'b1100000;
  localparam logic [6:0] C_START = 7'b0011000;
  localparam logic [6:0] C_BUSY  = 7'b0010010;
  localparam logic [6:0] C_TO    = 7'b0010011;
  localparam logic [6:0] C_DONE  = 7'b0000100;

  localparam logic [31:0] NOP = 32'd0;

  function automatic logic [15:0] exp_of(input logic [4:0] en, input logic [6:0] ctl,
                                         input logic [1:0] ba, input logic [1:0] bb);
    return {en, ctl, ba, bb};
  endfunction

  function automatic logic [31:0] r_ins(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] aluop);
    return {5'b00000, rd, rs, rt, 5'b00000, aluop, 2'b00};
  endfunction

  function automatic logic [31:0] i_ins(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs);
    return {op, rd, rs, 17'd0};
  endfunction

  task automatic check_output();
    logic [15:0] got, exp;
    string tag;
    got = {en_pc, en_fd, en_dx, en_xm, en_mw, flush_fd, flush_dx, bubble_xm,
           md_start, md_result_sel, md_busy, md_timeout, byp_a_sel, byp_b_sel};
    exp = exp_q.pop_front();
    tag = tag_q.pop_front();
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else $error("[TB] FAIL %s: observed %b expected %b", tag, got, exp);
  endtask

  task automatic apply_stimulus(input logic rst, input logic br, input logic rdy,
                                input logic [31:0] fd, input logic [31:0] dx,
                                input logic [31:0] xm, input logic [31:0] mw,
                                input logic [15:0] exp, input string tag);
    @(negedge clock);
    reset          = rst;
    branch_taken_x = br;
    md_result_rdy  = rdy;
    insn_fd        = fd;
    insn_dx        = dx;
    insn_xm        = xm;
    insn_mw        = mw;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    #2;
    check_output();
  endtask

  logic [31:0] add_r3, sub_r4, or_r10, add_r9, lw_r5, lw_r0, add_r6, sw_r5, bne_34, mul_r7;
  logic [15:0] e_def;

  initial begin
    add_r3 = r_ins(5'd3, 5'd1, 5'd2, 5'b00000);
    sub_r4 = r_ins(5'd4, 5'd3, 5'd1, 5'b00001);
    or_r10 = r_ins(5'd10, 5'd3, 5'd4, 5'b00011);
    add_r9 = r_ins(5'd9, 5'd1, 5'd3, 5'b00000);
    lw_r5  = i_ins(5'b01000, 5'd5, 5'd1);
    lw_r0  = i_ins(5'b01000, 5'd0, 5'd1);
    add_r6 = r_ins(5'd6, 5'd5, 5'd5, 5'b00000);
    sw_r5  = i_ins(5'b00111, 5'd5, 5'd2);
    bne_34 = i_ins(5'b00010, 5'd3, 5'd4);
    mul_r7 = r_ins(5'd7, 5'd1, 5'd2, 5'b00110);
    e_def  = exp_of(EN_ALL, C_NONE, 2'b00, 2'b00);

    reset = 1'b1; branch_taken_x = 1'b0; md_result_rdy = 1'b0;
    insn_fd = NOP; insn_dx = NOP; insn_xm = NOP; insn_mw = NOP;

    // Reset forces quiet outputs even with a mul/div sitting in D/X
    apply_stimulus(1, 0, 0, NOP, mul_r7, NOP, NOP, e_def, "reset_mul");
    apply_stimulus(1, 1, 0, add_r6, lw_r5, add_r3, NOP, e_def, "reset_hz");
    apply_stimulus(0, 0, 0, NOP, NOP, NOP, NOP, e_def, "idle_default");

    // Bypass from X/M and M/W with X/M priority
    apply_stimulus(0, 0, 0, NOP, sub_r4, add_r3, NOP, exp_of(EN_ALL, C_NONE, 2'b01, 2'b00), "byp_xm_a");
    apply_stimulus(0, 0, 0, NOP, or_r10, sub_r4, add_r3, exp_of(EN_ALL, C_NONE, 2'b10, 2'b01), "byp_mw_a_xm_b");
    apply_stimulus(0, 0, 0, NOP, sub_r4, add_r3, add_r3, exp_of(EN_ALL, C_NONE, 2'b01, 2'b00), "byp_xm_prio");
    apply_stimulus(0, 0, 0, NOP, add_r9, add_r3, NOP, exp_of(EN_ALL, C_NONE, 2'b00, 2'b01), "byp_xm_b");
    apply_stimulus(0, 0, 0, NOP, bne_34, sub_r4, add_r3, exp_of(EN_ALL, C_NONE, 2'b10, 2'b01), "byp_bne");

    // Load-use stall, then no bypass from lw in X/M, then M/W bypass
    apply_stimulus(0, 0, 0, add_r6, lw_r5, NOP, NOP, exp_of(EN_LU, C_LU, 2'b00, 2'b00), "loaduse");
    apply_stimulus(0, 0, 0, NOP, add_r6, lw_r5, NOP, e_def, "lw_in_xm");
    apply_stimulus(0, 0, 0, NOP, add_r6, NOP, lw_r5, exp_of(EN_ALL, C_NONE, 2'b10, 2'b10), "lw_in_mw");
    apply_stimulus(0, 0, 0, sw_r5, lw_r5, NOP, NOP, exp_of(EN_LU, C_LU, 2'b00, 2'b00), "loaduse_sw_b");
    apply_stimulus(0, 0, 0, NOP, lw_r0, NOP, NOP, e_def, "lw_r0_nohz");

    // Branch overrides a coincident load-use
    apply_stimulus(0, 1, 0, add_r6, lw_r5, NOP, NOP, exp_of(EN_ALL, C_BR, 2'b00, 2'b00), "branch_over_lu");

    // mul with rdy 5 cycles after start
    apply_stimulus(0, 0, 0, NOP, mul_r7, NOP, NOP, exp_of(EN_MD, C_START, 2'b00, 2'b00), "mul_start");
    for (int i = 0; i < 4; i++)
      apply_stimulus(0, (i == 1), 0, add_r6, mul_r7, NOP, NOP, exp_of(EN_MD, C_BUSY, 2'b00, 2'b00), "mul_busy");
    apply_stimulus(0, 0, 1, NOP, mul_r7, NOP, NOP, exp_of(EN_MD, C_BUSY, 2'b00, 2'b00), "mul_busy_rdy");
    apply_stimulus(0, 0, 0, NOP, mul_r7, NOP, NOP, exp_of(EN_ALL, C_DONE, 2'b00, 2'b00), "mul_done");
    apply_stimulus(0, 0, 0, NOP, NOP, NOP, NOP, e_def, "mul_idle");

    // Timeout after the 8th busy cycle
    apply_stimulus(0, 0, 0, NOP, mul_r7, NOP, NOP, exp_of(EN_MD, C_START, 2'b00, 2'b00), "to_start");
    for (int i = 0; i < 7; i++)
      apply_stimulus(0, 0, 0, NOP, mul_r7, NOP, NOP, exp_of(EN_MD, C_BUSY, 2'b00, 2'b00), "to_busy");
    apply_stimulus(0, 0, 0, NOP, mul_r7, NOP, NOP, exp_of(EN_MD, C_TO, 2'b00, 2'b00), "to_pulse");
    apply_stimulus(0, 0, 0, NOP, mul_r7, NOP, NOP, exp_of(EN_ALL, C_DONE, 2'b00, 2'b00), "to_done");
    apply_stimulus(0, 0, 0, NOP, NOP, NOP, NOP, e_def, "to_idle");

    // rdy coincident with the timeout cycle suppresses md_timeout
    apply_stimulus(0, 0, 0, NOP, mul_r7, NOP, NOP, exp_of(EN_MD, C_START, 2'b00, 2'b00), "co_start");
    for (int i = 0; i < 7; i++)
      apply_stimulus(0, 0, 0, NOP, mul_r7, NOP, NOP, exp_of(EN_MD, C_BUSY, 2'b00, 2'b00), "co_busy");
    apply_stimulus(0, 0, 1, NOP, mul_r7, NOP, NOP, exp_of(EN_MD, C_BUSY, 2'b00, 2'b00), "co_rdy_no_to");
    apply_stimulus(0, 0, 0, NOP, mul_r7, NOP, NOP, exp_of(EN_ALL, C_DONE, 2'b00, 2'b00), "co_done");

    // Reset during the 3rd busy cycle aborts cleanly, then a fresh mul restarts
    apply_stimulus(0, 0, 0, NOP, mul_r7, NOP, NOP, exp_of(EN_MD, C_START, 2'b00, 2'b00), "rst_start");
    apply_stimulus(0, 0, 0, NOP, mul_r7, NOP, NOP, exp_of(EN_MD, C_BUSY, 2'b00, 2'b00), "rst_busy1");
    apply_stimulus(0, 0, 0, NOP, mul_r7, NOP, NOP, exp_of(EN_MD, C_BUSY, 2'b00, 2'b00), "rst_busy2");
    apply_stimulus(1, 0, 0, NOP, mul_r7, NOP, NOP, e_def, "rst_in_busy3");
    apply_stimulus(0, 0, 0, NOP, NOP, NOP, NOP, e_def, "rst_after");
    apply_stimulus(0, 0, 0, NOP, mul_r7, NOP, NOP, exp_of(EN_MD, C_START, 2'b00, 2'b00), "rst_restart");
    apply_stimulus(0, 0, 1, NOP, mul_r7, NOP, NOP, exp_of(EN_MD, C_BUSY, 2'b00, 2'b00), "rst_busy_rdy");
    apply_stimulus(0, 0, 0, NOP, mul_r7, NOP, NOP, exp_of(EN_ALL, C_DONE, 2'b00, 2'b00), "rst_done");
    apply_stimulus(0, 0, 0, NOP, NOP, NOP, NOP, e_def, "final_idle");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
